vector_store_unit: RTL and testbench

VECTOR_STORE_UNIT -- requirements
Module: vector_store_unit

---
 rtl/vector_store_unit.sv | 131 +++++++++++++
 tb/tb_vector_store_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_store_unit.sv
// Vector store unit: streams one lane per cycle into data RAM from a registered copy of the request.
// Build option: define VECTOR_STORE_MASK_EN to add the lane_mask port and per-lane write enables.
//
//   state | meaning
//   IDLE  | ready for a request (store_ready=1)
//   STORE | writing lane cnt_q at base_q+cnt_q
//   DONE  | one-cycle completion pulse
`timescale 1ns/1ps
module vector_store_unit #(
    parameter int LANES  = 16,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    store_valid,
    output logic                    store_ready,
    input  logic [ADDR_W-1:0]       base_address,
    input  logic [LANES*LANE_W-1:0] vector_data,
`ifdef VECTOR_STORE_MASK_EN
    input  logic [LANES-1:0]        lane_mask,
`endif
    input  logic                    flush,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [LANE_W-1:0]       mem_data,
    output logic                    mem_wren,
    output logic                    stall,
    output logic                    done
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [LANES*LANE_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0]       addr_hold_q;
    logic [LANE_W-1:0]       data_hold_q;
    logic [ADDR_W-1:0]       cur_addr;
    logic [LANE_W-1:0]       cur_data;
    logic                    lane_en;

    assign cur_addr = base_q + ADDR_W'(cnt_q);
    assign cur_data = data_q[cnt_q*LANE_W +: LANE_W];

`ifdef VECTOR_STORE_MASK_EN
    logic [LANES-1:0] mask_q, mask_d;

    assign lane_en = mask_q[cnt_q];

    always_comb begin
        mask_d = mask_q;
        if (!flush && state_q == IDLE && store_valid) begin
            mask_d = lane_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign lane_en = 1'b1;
`endif

    // flush wins over everything, including a handshake in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        data_d  = data_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_valid) begin
                        state_d = STORE;
                        cnt_d   = '0;
                        base_d  = base_address;
                        data_d  = vector_data;
                    end
                end
                STORE: begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            data_q      <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            data_q  <= data_d;
            if (state_q == STORE) begin
                addr_hold_q <= cur_addr;
                data_hold_q <= cur_data;
            end
        end
    end

    // Outputs decode from state so an async reset silences the RAM port immediately
    assign mem_address = (state_q == STORE) ? cur_addr : addr_hold_q;
    assign mem_data    = (state_q == STORE) ? cur_data : data_hold_q;
    assign mem_wren    = (state_q == STORE) && lane_en;
    assign done        = (state_q == DONE);
    assign store_ready = (state_q == IDLE);
    assign stall       = ~store_ready;

endmodule

// File: tb/tb_vector_store_unit.sv
// Scoreboard bench for vector_store_unit: expected writes and done cycles are queued at request time
// and matched at the negedge when the DUT produces them.
`timescale 1ns/1ps
module tb_vector_store_unit;
    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 12;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    store_valid;
    logic                    store_ready;
    logic [ADDR_W-1:0]       base_address;
    logic [LANES*LANE_W-1:0] vector_data;
`ifdef VECTOR_STORE_MASK_EN
    logic [LANES-1:0]        lane_mask;
`endif
    logic                    flush;
    logic [ADDR_W-1:0]       mem_address;
    logic [LANE_W-1:0]       mem_data;
    logic                    mem_wren;
    logic                    stall;
    logic                    done;

    vector_store_unit #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .store_valid  (store_valid),
        .store_ready  (store_ready),
        .base_address (base_address),
        .vector_data  (vector_data),
`ifdef VECTOR_STORE_MASK_EN
        .lane_mask    (lane_mask),
`endif
        .flush        (flush),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .stall        (stall),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, act, exp, cyc);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [LANE_W-1:0] d;
        int                c;
    } wr_t;

    wr_t sb[$];
    int  done_exp[$];

    always @(negedge clk) begin : mon
        wr_t e;
        int  dc;
        if (mem_wren) begin
            if (sb.size() == 0) begin
                check("spurious_write", {31'b0, mem_wren}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr",  {20'b0, mem_address}, {20'b0, e.a});
                check("wr_data",  {24'b0, mem_data},    {24'b0, e.d});
                check("wr_cycle", cyc, e.c);
            end
        end
        if (done) begin
            if (done_exp.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                dc = done_exp.pop_front();
                check("done_cycle", cyc, dc);
            end
        end
    end

    // Lane k of a request accepted at handshake cycle h appears at negedge cyc==h+k; done at h+LANES.
    task automatic push_exp(input logic [ADDR_W-1:0] b, input logic [LANES*LANE_W-1:0] v,
                            input logic [LANES-1:0] m, input int nl, input int h, input bit exp_done);
        wr_t e;
        for (int k = 0; k < nl; k++) begin
            if (m[k]) begin
                e.a = b + ADDR_W'(k);
                e.d = v[k*LANE_W +: LANE_W];
                e.c = h + k;
                sb.push_back(e);
            end
        end
        if (exp_done) done_exp.push_back(h + LANES);
    endtask

    task automatic scramble_inputs();
        base_address = ADDR_W'($urandom);
        vector_data  = {$urandom, $urandom, $urandom, $urandom};
`ifdef VECTOR_STORE_MASK_EN
        lane_mask    = LANES'($urandom);
`endif
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the handshake edge.
    task automatic start_store(input logic [ADDR_W-1:0] b, input logic [LANES*LANE_W-1:0] v,
                               input logic [LANES-1:0] m, input int nl, input bit exp_done,
                               output int h);
        store_valid  = 1'b1;
        base_address = b;
        vector_data  = v;
`ifdef VECTOR_STORE_MASK_EN
        lane_mask    = m;
`endif
        @(posedge clk); #1;
        h = cyc;
        store_valid = 1'b0;
        scramble_inputs();
        push_exp(b, v, m, nl, h, exp_done);
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic wait_after_edge(input int n);
        do begin @(posedge clk); #1; end while (cyc < n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int h, h1;
        logic [LANES*LANE_W-1:0] v, va, vb;

        reset = 1'b0; store_valid = 1'b0; flush = 1'b0;
        base_address = '0; vector_data = '0;
`ifdef VECTOR_STORE_MASK_EN
        lane_mask = '0;
`endif
        #12;
        check("rst_ready", {31'b0, store_ready}, 32'd1);
        check("rst_stall", {31'b0, stall},       32'd0);
        check("rst_wren",  {31'b0, mem_wren},    32'd0);
        check("rst_addr",  {20'b0, mem_address}, 32'd0);
        check("rst_data",  {24'b0, mem_data},    32'd0);
        check("rst_done",  {31'b0, done},        32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // ascending lanes at base 0x010
        for (int k = 0; k < LANES; k++) v[k*LANE_W +: LANE_W] = LANE_W'(k);
        start_store(12'h010, v, '1, LANES, 1'b1, h);
        wait_neg(h + 15);
        check("busy_stall", {31'b0, stall}, 32'd1);
        wait_neg(h + 16);
        check("ready_at_done", {31'b0, store_ready}, 32'd0);
        wait_neg(h + 17);
        check("ready_after_done", {31'b0, store_ready}, 32'd1);
        check("idle_stall",       {31'b0, stall},       32'd0);
        check("idle_wren",        {31'b0, mem_wren},    32'd0);
        check("hold_addr",        {20'b0, mem_address}, 32'h01F);
        check("hold_data",        {24'b0, mem_data},    32'h0F);
        @(posedge clk); #1;

        // address wrap from 0xFFE
        v = {$urandom, $urandom, $urandom, $urandom};
        start_store(12'hFFE, v, '1, LANES, 1'b1, h);
        wait_neg(h + 2);
        check("wrap_lane2_addr", {20'b0, mem_address}, 32'h000);
        wait_neg(h + 15);
        check("wrap_lane15_addr", {20'b0, mem_address}, 32'h00D);
        wait_neg(h + 17);
        @(posedge clk); #1;

        // flush while lane 5 is written
        v = {$urandom, $urandom, $urandom, $urandom};
        start_store(12'h100, v, '1, 6, 1'b0, h);
        wait_after_edge(h + 5);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'b0, store_ready}, 32'd1);
        check("flush_wren",  {31'b0, mem_wren},    32'd0);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;

        // flush beats a simultaneous handshake
        store_valid = 1'b1; flush = 1'b1; base_address = 12'h555;
        @(posedge clk); #1;
        store_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_hs_ready", {31'b0, store_ready}, 32'd1);
        check("flush_hs_wren",  {31'b0, mem_wren},    32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // async reset mid-STORE, between edges
        v = {$urandom, $urandom, $urandom, $urandom};
        start_store(12'h200, v, '1, 3, 1'b0, h);
        wait_after_edge(h + 3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_wren",  {31'b0, mem_wren},    32'd0);
        check("arst_ready", {31'b0, store_ready}, 32'd1);
        check("arst_stall", {31'b0, stall},       32'd0);
        check("arst_done",  {31'b0, done},        32'd0);

        // request waiting across reset release, then held valid for back-to-back stores
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        store_valid = 1'b1; base_address = 12'h300; vector_data = va;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        h1 = cyc;
        push_exp(12'h300, va, '1, LANES, h1, 1'b1);
        base_address = 12'h7F8; vector_data = vb;
        push_exp(12'h7F8, vb, '1, LANES, h1 + LANES + 2, 1'b1);
        wait_after_edge(h1 + LANES + 2);
        store_valid = 1'b0;
        scramble_inputs();
        wait_neg(h1 + 2*LANES + 3);
        @(posedge clk); #1;

`ifdef VECTOR_STORE_MASK_EN
        v = {$urandom, $urandom, $urandom, $urandom};
        start_store(12'h400, v, 16'hAAAA, LANES, 1'b1, h);
        wait_neg(h + 4);
        check("mask_even_wren", {31'b0, mem_wren}, 32'd0);
        wait_neg(h + 17);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 50 && (sb.size() != 0 || done_exp.size() != 0); i++) @(negedge clk);
        check("sb_drain", sb.size() + done_exp.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
